// File: rtl/pov_pkg.sv
// Shared types and constants for the persistence-of-vision column driver.
package pov_pkg;

    // Default column width: one bit per LED row.
    localparam int COL_W_DEFAULT = 5;

    // Display sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } pov_state_t;

    // Font columns, leftmost column in the highest index. Bit 4 is the top row.
    localparam logic [3:0][4:0] FONT_P = {5'h1F, 5'h14, 5'h14, 5'h1C};
    localparam logic [3:0][4:0] FONT_R = {5'h1F, 5'h14, 5'h16, 5'h1D};
    localparam logic [3:0][4:0] FONT_A = {5'h1F, 5'h14, 5'h14, 5'h1F};
    localparam logic [3:0][4:0] FONT_S = {5'h1D, 5'h15, 5'h15, 5'h17};
    localparam logic [4:0][4:0] FONT_N = {5'h1F, 5'h08, 5'h04, 5'h02, 5'h1F};
    localparam logic [4:0]      FONT_GAP = 5'h00;

endpackage

// File: rtl/pov_sync_fifo.sv
// Small synchronous FIFO. The head entry is readable without a pop so the
// consumer can load it in the same edge that retires it.
module pov_sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == LVL_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign dout    = mem_reg[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/pov_column_driver.sv
// Buffers columns from the sequencer and paces them onto the LED bar:
// each column is held for HOLD_CYCLES clocks followed by BLANK_CYCLES of dark.
module pov_column_driver
    import pov_pkg::*;
#(
    parameter int COL_W        = COL_W_DEFAULT,
    parameter int DEPTH        = 8,
    parameter int HOLD_CYCLES  = 5,
    parameter int BLANK_CYCLES = 1,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             col_valid,
    input  logic [COL_W-1:0] col_data,
    output logic             col_ready,
    input  logic             clear_underrun,
    output logic [COL_W-1:0] led,
    output logic             col_strobe,
    output logic             underrun,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + BLANK_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

    pov_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [COL_W-1:0] led_reg, led_next;
    logic             strobe_reg, strobe_next;
    logic             underrun_reg;
    logic             set_underrun;
    logic             fifo_pop;
    logic [COL_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    pov_sync_fifo #(
        .WIDTH (COL_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (col_valid),
        .din   (col_data),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign col_ready  = !fifo_full;
    assign led        = led_reg;
    assign col_strobe = strobe_reg;
    assign underrun   = underrun_reg;

    // Registered sequencer state and LED outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            led_reg    <= '0;
            strobe_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            led_reg    <= led_next;
            strobe_reg <= strobe_next;
        end
    end

    // Sticky starvation flag; a new starvation beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underrun_reg <= 1'b0;
        end else if (set_underrun) begin
            underrun_reg <= 1'b1;
        end else if (clear_underrun) begin
            underrun_reg <= 1'b0;
        end
    end

    // Next-state logic; the end of a column (or its blank) funnels into one
    // shared decision: fetch the next column, flag starvation, or go idle.
    always_comb begin
        logic decide;
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        led_next     = led_reg;
        strobe_next  = 1'b0;
        fifo_pop     = 1'b0;
        set_underrun = 1'b0;
        decide       = 1'b0;

        case (state_reg)
            IDLE: begin
                led_next = '0;
                decide   = enable && !fifo_empty;
            end
            SHOW: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (BLANK_CYCLES > 0) begin
                    state_next = BLANK;
                    cnt_next   = BLANK_LOAD;
                    led_next   = '0;
                end else begin
                    decide = 1'b1;
                end
            end
            BLANK: begin
                led_next = '0;
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    decide = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                led_next   = '0;
            end
        endcase

        if (decide) begin
            if (enable && !fifo_empty) begin
                fifo_pop    = 1'b1;
                led_next    = fifo_head;
                cnt_next    = HOLD_LOAD;
                strobe_next = 1'b1;
                state_next  = SHOW;
            end else begin
                set_underrun = enable;
                led_next     = '0;
                state_next   = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_pov_column_driver.sv
// Directed bench for pov_column_driver: default timing instance plus a
// no-blank instance (HOLD_CYCLES=3, BLANK_CYCLES=0).
module tb_pov_column_driver;

    localparam int COL_W = 5;
    localparam int LVL_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, enable, col_valid, clear_underrun;
    logic [COL_W-1:0] col_data;
    logic             col_ready, col_strobe, underrun;
    logic [COL_W-1:0] led;
    logic [LVL_W-1:0] fifo_level;

    logic             b_rst_n, b_enable, b_col_valid, b_clear_underrun;
    logic [COL_W-1:0] b_col_data;
    logic             b_col_ready, b_col_strobe, b_underrun;
    logic [COL_W-1:0] b_led;
    logic [LVL_W-1:0] b_fifo_level;

    int n_cmp = 0;
    int n_bad = 0;

    pov_column_driver dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .col_valid(col_valid),
        .col_data(col_data), .col_ready(col_ready), .clear_underrun(clear_underrun),
        .led(led), .col_strobe(col_strobe), .underrun(underrun), .fifo_level(fifo_level)
    );

    pov_column_driver #(.HOLD_CYCLES(3), .BLANK_CYCLES(0)) dut_nb (
        .clk(clk), .rst_n(b_rst_n), .enable(b_enable), .col_valid(b_col_valid),
        .col_data(b_col_data), .col_ready(b_col_ready), .clear_underrun(b_clear_underrun),
        .led(b_led), .col_strobe(b_col_strobe), .underrun(b_underrun), .fifo_level(b_fifo_level)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; col_valid = 1'b0; col_data = '0; clear_underrun = 1'b0;
        b_rst_n = 1'b0; b_enable = 1'b0; b_col_valid = 1'b0; b_col_data = '0; b_clear_underrun = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        n_cmp++; if (led !== 5'h00) begin n_bad++; $display("FAIL reset_led: got %h want 00", led); end
        n_cmp++; if (col_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b want 0", col_strobe); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_cmp++; if (col_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", col_ready); end
        $display("reset: led=%h level=%0d ready=%b", led, fifo_level, col_ready);
    endtask

    // Letter P plus a gap column, pushed back-to-back with display enabled.
    task automatic test_stream();
        logic [4:0] vec [5];
        logic [4:0] exp_led;
        logic       exp_stb;
        int         p, c;
        vec = '{5'h1F, 5'h14, 5'h14, 5'h1C, 5'h00};
        enable = 1'b1;
        for (int k = 0; k < 34; k++) begin
            col_valid = (k < 5);
            col_data  = (k < 5) ? vec[k] : 5'h00;
            step();
            exp_led = 5'h00;
            exp_stb = 1'b0;
            if (k >= 1 && k <= 30) begin
                p = (k - 1) % 6;
                c = (k - 1) / 6;
                exp_led = (p < 5) ? vec[c] : 5'h00;
                exp_stb = (p == 0);
            end
            n_cmp++; if (led !== exp_led) begin n_bad++; $display("FAIL stream_led[%0d]: got %h want %h", k, led, exp_led); end
            n_cmp++; if (col_strobe !== exp_stb) begin n_bad++; $display("FAIL stream_strobe[%0d]: got %b want %b", k, col_strobe, exp_stb); end
            n_cmp++; if (underrun !== (k >= 31)) begin n_bad++; $display("FAIL stream_underrun[%0d]: got %b want %b", k, underrun, (k >= 31)); end
            if (k == 0) begin
                n_cmp++; if (fifo_level !== 4'd1) begin n_bad++; $display("FAIL stream_level0: got %0d want 1", fifo_level); end
            end
            $display("stream k=%0d led=%h strobe=%b underrun=%b level=%0d", k, led, col_strobe, underrun, fifo_level);
        end
        col_valid = 1'b0;
    endtask

    task automatic test_underrun_clear();
        clear_underrun = 1'b1;
        step();
        clear_underrun = 1'b0;
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL clear_underrun: got %b want 0", underrun); end
        $display("clear: underrun=%b", underrun);
        // One column: pushed at j=0, starvation decision lands on j=7.
        for (int j = 0; j < 8; j++) begin
            col_valid      = (j == 0);
            col_data       = 5'h0A;
            clear_underrun = (j == 7);
            step();
            if (j == 6) begin
                n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL pre_starve_underrun: got %b want 0", underrun); end
            end
            $display("starve j=%0d led=%h underrun=%b", j, led, underrun);
        end
        clear_underrun = 1'b0;
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL set_beats_clear: got %b want 1", underrun); end
        clear_underrun = 1'b1;
        step();
        clear_underrun = 1'b0;
    endtask

    task automatic test_backpressure();
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            col_valid = 1'b1;
            col_data  = 5'(i + 1);
            step();
            $display("fill i=%0d level=%0d ready=%b", i, fifo_level, col_ready);
        end
        n_cmp++; if (fifo_level !== 4'd8) begin n_bad++; $display("FAIL full_level: got %0d want 8", fifo_level); end
        n_cmp++; if (col_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", col_ready); end
        col_data = 5'h09;
        step();
        n_cmp++; if (fifo_level !== 4'd8) begin n_bad++; $display("FAIL held_level: got %0d want 8", fifo_level); end
        enable = 1'b1;
        step();
        n_cmp++; if (fifo_level !== 4'd7) begin n_bad++; $display("FAIL first_pop_level: got %0d want 7", fifo_level); end
        n_cmp++; if (col_ready !== 1'b1) begin n_bad++; $display("FAIL first_pop_ready: got %b want 1", col_ready); end
        n_cmp++; if (led !== 5'h01) begin n_bad++; $display("FAIL first_pop_led: got %h want 01", led); end
        n_cmp++; if (col_strobe !== 1'b1) begin n_bad++; $display("FAIL first_pop_strobe: got %b want 1", col_strobe); end
        step();
        col_valid = 1'b0;
        n_cmp++; if (fifo_level !== 4'd8) begin n_bad++; $display("FAIL ninth_accept_level: got %0d want 8", fifo_level); end
        n_cmp++; if (col_ready !== 1'b0) begin n_bad++; $display("FAIL ninth_accept_ready: got %b want 0", col_ready); end
        $display("backpressure: level=%0d ready=%b led=%h", fifo_level, col_ready, led);
    endtask

    task automatic test_reset_mid_show();
        rst_n = 1'b0; enable = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            col_valid = 1'b1;
            col_data  = 5'(5'h15 + i);
            step();
        end
        col_valid = 1'b0;
        enable = 1'b1;
        step();
        n_cmp++; if (fifo_level !== 4'd4) begin n_bad++; $display("FAIL mid_show_level: got %0d want 4", fifo_level); end
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++; if (led !== 5'h00) begin n_bad++; $display("FAIL rst_mid_led: got %h want 00", led); end
        n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL rst_mid_level: got %0d want 0", fifo_level); end
        n_cmp++; if (col_strobe !== 1'b0) begin n_bad++; $display("FAIL rst_mid_strobe: got %b want 0", col_strobe); end
        n_cmp++; if (col_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", col_ready); end
        $display("reset mid-show: led=%h level=%0d ready=%b", led, fifo_level, col_ready);
    endtask

    task automatic test_enable_drop();
        logic [4:0] exp_led;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            col_valid = 1'b1;
            col_data  = 5'(5'h11 + i);
            step();
        end
        col_valid = 1'b0;
        enable = 1'b1;
        step();
        n_cmp++; if (led !== 5'h11) begin n_bad++; $display("FAIL drop_first_led: got %h want 11", led); end
        n_cmp++; if (col_strobe !== 1'b1) begin n_bad++; $display("FAIL drop_first_strobe: got %b want 1", col_strobe); end
        step();
        enable = 1'b0;
        for (int e = 3; e <= 8; e++) begin
            step();
            exp_led = (e <= 5) ? 5'h11 : 5'h00;
            n_cmp++; if (led !== exp_led) begin n_bad++; $display("FAIL drop_led[%0d]: got %h want %h", e, led, exp_led); end
            n_cmp++; if (col_strobe !== 1'b0) begin n_bad++; $display("FAIL drop_strobe[%0d]: got %b want 0", e, col_strobe); end
            $display("enable drop e=%0d led=%h level=%0d", e, led, fifo_level);
        end
        n_cmp++; if (fifo_level !== 4'd2) begin n_bad++; $display("FAIL drop_level: got %0d want 2", fifo_level); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL drop_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_no_blank();
        logic [4:0] c [8];
        c = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08};
        b_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_col_valid = 1'b1;
            b_col_data  = c[i];
            step();
        end
        b_enable = 1'b1;
        for (int n = 0; n < 15; n++) begin
            b_col_valid = (n % 3 == 0);
            b_col_data  = c[3 + n / 3];
            step();
            n_cmp++; if (b_fifo_level !== 4'd3) begin n_bad++; $display("FAIL nb_level[%0d]: got %0d want 3", n, b_fifo_level); end
            n_cmp++; if (b_led !== c[n / 3]) begin n_bad++; $display("FAIL nb_led[%0d]: got %h want %h", n, b_led, c[n / 3]); end
            n_cmp++; if (b_col_strobe !== (n % 3 == 0)) begin n_bad++; $display("FAIL nb_strobe[%0d]: got %b want %b", n, b_col_strobe, (n % 3 == 0)); end
            $display("no-blank n=%0d led=%h strobe=%b level=%0d", n, b_led, b_col_strobe, b_fifo_level);
        end
        b_col_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_underrun_clear();
        test_backpressure();
        test_reset_mid_show();
        test_enable_drop();
        test_no_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
